// File: rtl/mem_controller.sv
// Buffers a contiguous block of DMA words from core_control, then streams the
// block to the processing unit over a valid/ready handshake.
module mem_controller #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              mc_clk,
  input  logic              mc_reset,
  input  logic [ADDR_W-1:0] mc_data_address_in,
  input  logic              mc_we,
  input  logic [DATA_W-1:0] mc_data_in,
  input  logic              mc_valid_in,
  input  logic              mc_last_data,
  input  logic              mc_out_ready,
  input  logic              procc_done,
  input  logic              mc_clear,
  output logic [DATA_W-1:0] mc_data_out,
  output logic              mc_out_valid,
  output logic              mc_cont_procc,
  output logic              mc_data_done,
  output logic              mc_err,
  output logic [ADDR_W:0]   mc_word_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_STREAM,
    S_WAIT_PROCC,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

  state_t            state, state_next;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] expected_addr;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   remaining;
  logic              wr_event;
  logic              mem_we;
  logic              fill_ok;
  logic              load;
  logic              unload;

  assign wr_event      = mc_we && mc_valid_in;
  assign expected_addr = start_addr + count[ADDR_W-1:0];
  assign fill_ok       = (mc_data_address_in == expected_addr) && (count != FULL_COUNT);
  assign load          = (state == S_STREAM) && !wr_event && (remaining != '0)
                         && (!mc_out_valid || mc_out_ready);
  assign unload        = (state == S_STREAM) && mc_out_valid && mc_out_ready
                         && (remaining == '0);

  assign mc_cont_procc = (state == S_STREAM) || (state == S_WAIT_PROCC);
  assign mc_data_done  = (state == S_DONE);
  assign mc_err        = (state == S_ERR);
  assign mc_word_count = count;

  always_comb begin
    state_next = state;
    mem_we     = 1'b0;
    case (state)
      S_IDLE: begin
        if (wr_event) begin
          mem_we     = 1'b1;
          state_next = mc_last_data ? S_STREAM : S_FILL;
        end
      end
      S_FILL: begin
        if (wr_event) begin
          if (!fill_ok) begin
            state_next = S_ERR;
          end else begin
            mem_we = 1'b1;
            if (mc_last_data) state_next = S_STREAM;
          end
        end
      end
      S_STREAM: begin
        if (wr_event)    state_next = S_ERR;
        else if (unload) state_next = S_WAIT_PROCC;
      end
      S_WAIT_PROCC: begin
        if (wr_event)        state_next = S_ERR;
        else if (procc_done) state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      S_ERR:   if (mc_clear) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Buffer storage is deliberately left out of reset.
  always_ff @(posedge mc_clk) begin
    if (mem_we) mem[mc_data_address_in] <= mc_data_in;
  end

  always_ff @(posedge mc_clk or negedge mc_reset) begin
    if (!mc_reset) begin
      state        <= S_IDLE;
      start_addr   <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      remaining    <= '0;
      mc_data_out  <= '0;
      mc_out_valid <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (wr_event) begin
            start_addr <= mc_data_address_in;
            rd_ptr     <= mc_data_address_in;
            count      <= (ADDR_W+1)'(1);
            remaining  <= (ADDR_W+1)'(1);
          end
        end
        S_FILL: begin
          // rd_ptr/remaining track the block so they are ready on STREAM entry.
          if (wr_event && fill_ok) begin
            count     <= count + (ADDR_W+1)'(1);
            remaining <= count + (ADDR_W+1)'(1);
            rd_ptr    <= start_addr;
          end
        end
        S_STREAM: begin
          if (load) begin
            mc_data_out  <= mem[rd_ptr];
            mc_out_valid <= 1'b1;
            rd_ptr       <= rd_ptr + 1'b1;
            remaining    <= remaining - (ADDR_W+1)'(1);
          end else if (unload) begin
            mc_out_valid <= 1'b0;
          end
        end
        S_DONE: count <= '0;
        S_ERR: begin
          mc_out_valid <= 1'b0;
          if (mc_clear) count <= '0;
        end
        default: ;
      endcase
      if (state_next == S_ERR) mc_out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/mem_controller.md
Name: mem_controller

Overview:
- Memory controller stage directly downstream of core_control.
- Consumes the write-address/write-enable stream that core_control drives for DMA data. Stores the words in a local buffer.
- Once the last word has arrived, streams the buffered operands to the processing unit through a valid/ready handshake.
- Returns mc_cont_procc, mc_data_done and mc_err to core_control.

Parameters:
DATA_W, 32, data word width
ADDR_W, 6, address width (matches core_control address bus)
DEPTH, 64, buffer entries (must equal 2**ADDR_W)

Ports:
mc_clk  input  1  clock, rising edge
mc_reset  input  1  asynchronous, active-low reset
mc_data_address_in  input  ADDR_W  write address from core_control
mc_we  input  1  write enable from core_control
mc_data_in  input  DATA_W  DMA write data
mc_valid_in  input  1  DMA data valid; a write occurs only when mc_we && mc_valid_in
mc_last_data  input  1  qualifies the current write as the final word of the block
mc_out_ready  input  1  processing unit accepts mc_data_out
procc_done  input  1  processing unit finished the current block
mc_clear  input  1  clears a sticky error, returns to IDLE
mc_data_out  output  DATA_W  operand to processing unit (registered)
mc_out_valid  output  1  mc_data_out valid
mc_cont_procc  output  1  high while in STREAM or WAIT_PROCC
mc_data_done  output  1  one-cycle pulse when the block completes
mc_err  output  1  sticky error flag
mc_word_count  output  ADDR_W+1  words currently buffered

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - All outputs 0: mc_data_out, mc_out_valid, mc_cont_procc, mc_data_done, mc_err, mc_word_count.
  - Internal start_addr, rd_ptr and remaining counter = 0.
  - Buffer contents are not reset.
  - Reset mid-operation aborts immediately; no done pulse.
- Write event W = mc_we && mc_valid_in. mc_valid_in without mc_we is ignored.
- IDLE, on W:
  - mem[addr] <= data; start_addr <= addr; count <= 1.
  - If mc_last_data: go to STREAM. Else go to FILL.
- FILL, on W:
  - Expected address = (start_addr + count) mod DEPTH.
  - If addr != expected, or count == DEPTH: go to ERR; the word is not written.
  - Otherwise write the word and count++.
  - If mc_last_data on this write: go to STREAM.
- STREAM:
  - On entry: rd_ptr = start_addr, remaining = count.
  - Load rule: when remaining>0 && (!mc_out_valid || mc_out_ready), then mc_data_out <= mem[rd_ptr], mc_out_valid <= 1, rd_ptr++ (wraps mod DEPTH), remaining--.
  - Unload rule: when mc_out_valid && mc_out_ready && remaining==0, mc_out_valid <= 0.
  - Latency: first word valid 1 cycle after entering STREAM. Throughput 1 word/cycle with mc_out_ready held high.
  - mc_data_out is held stable while mc_out_valid && !mc_out_ready.
  - Leaves STREAM for WAIT_PROCC when the final word is accepted.
  - Any W during STREAM goes to ERR.
- WAIT_PROCC:
  - On procc_done: go to DONE.
  - W here goes to ERR.
- DONE:
  - mc_data_done=1 for exactly one cycle, count <= 0, then go to IDLE.
  - procc_done arriving before WAIT_PROCC is ignored.
- ERR:
  - mc_err=1 (sticky); mc_out_valid <= 0; mc_cont_procc=0; writes ignored.
  - mc_clear: go to IDLE with count=0 and mc_err=0 on the next edge.
- Simultaneous events:
  - mc_clear outside ERR is ignored.
  - A W with mc_last_data when count==DEPTH-1 is legal (buffer becomes full, 64 words).
  - Address wrap: start_addr=62 with 4 words uses addresses 62, 63, 0, 1.
- mc_word_count reflects count; it is combinationally stable from registers only.

Test Plan:
- Reset then a 4-word block at addr 0..3, data 0xA0..0xA3, last on the 4th word, mc_out_ready=1 -> mc_data_out = A0, A1, A2, A3 on consecutive cycles; mc_cont_procc=1; procc_done pulse -> mc_data_done high one cycle; state returns to IDLE.
- Same block with mc_out_ready toggled 1,0,0,1,… -> each word held stable while not ready; no words lost or duplicated; 4 transfers total.
- Wrap: start addr 62, 4 words 0x10..0x13 -> stream order 0x10..0x13, reads from 62, 63, 0, 1; mc_word_count=4 before streaming.
- Write addr 0, then addr 2 (skips 1) -> mc_err=1 on the next cycle, mc_out_valid=0; mc_clear -> mc_err=0, IDLE, mc_word_count=0.
- 64 sequential writes with last on the 64th -> 64 words streamed; a 65th write without last -> mc_err=1.
- Assert mc_reset=0 mid-STREAM after 2 of 4 words -> all outputs 0 asynchronously; no mc_data_done pulse; a new block after release streams correctly.
